vga_draw_arbiter: RTL and testbench



---
 rtl/vga_draw_arbiter.sv | 122 ++++++++++++
 tb/tb_vga_draw_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - round-robin owner of the shared VGA write port among drawing engines
// Optional build macro ARB_CLIP_EN suppresses writes outside SCREEN_W x SCREEN_H.
module vga_draw_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IDX_W    = 2,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   eng_done,
    input  logic [NUM_REQ-1:0]   eng_we,
    input  logic [8*NUM_REQ-1:0] eng_x,
    input  logic [7*NUM_REQ-1:0] eng_y,
    input  logic [3*NUM_REQ-1:0] eng_color,
    output logic [NUM_REQ-1:0]   eng_go,
    output logic [NUM_REQ-1:0]   eng_resetn,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_color,
    output logic                 vga_we,
    output logic                 busy,
    output logic [IDX_W-1:0]     owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             owner_done;
    logic             owner_req;
    logic [7:0]       fwd_x;
    logic [6:0]       fwd_y;
    logic [2:0]       fwd_color;
    logic             fwd_we;
    logic             fwd_we_ok;
    logic [NUM_REQ-1:0] owner_onehot;

    // Search starts just past the last owner so it is considered last.
    always_comb begin
        winner = owner_q;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(owner_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        owner_onehot = '0;
        owner_done   = 1'b0;
        owner_req    = 1'b0;
        fwd_x        = '0;
        fwd_y        = '0;
        fwd_color    = '0;
        fwd_we       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_onehot[i] = 1'b1;
                owner_done      = eng_done[i];
                owner_req       = req[i];
                fwd_x           = eng_x[8*i +: 8];
                fwd_y           = eng_y[7*i +: 7];
                fwd_color       = eng_color[3*i +: 3];
                fwd_we          = eng_we[i];
            end
        end
    end

`ifdef ARB_CLIP_EN
    assign fwd_we_ok = fwd_we && (int'(fwd_x) < SCREEN_W) && (int'(fwd_y) < SCREEN_H);
`else
    logic unused_screen;
    assign unused_screen = ^{SCREEN_W, SCREEN_H};
    assign fwd_we_ok     = fwd_we;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            owner_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner_q <= winner;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // Done and abort both just hand the port back.
                    if (owner_done || !owner_req)
                        state <= RELEASE;
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state == BUSY) || (state == RELEASE);
    assign owner      = owner_q;
    assign eng_go     = (state == BUSY) ? owner_onehot : '0;
    assign eng_resetn = {NUM_REQ{resetn}} & ~((state == RELEASE) ? owner_onehot : '0);
    assign vga_x      = (state == BUSY) ? fwd_x : '0;
    assign vga_y      = (state == BUSY) ? fwd_y : '0;
    assign vga_color  = (state == BUSY) ? fwd_color : '0;
    assign vga_we     = (state == BUSY) && fwd_we_ok;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb/tb_vga_draw_arbiter.sv - directed self-checking bench for vga_draw_arbiter
module tb_vga_draw_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  eng_done;
    logic [3:0]  eng_we;
    logic [31:0] eng_x;
    logic [27:0] eng_y;
    logic [11:0] eng_color;
    logic [3:0]  eng_go;
    logic [3:0]  eng_resetn;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_color;
    logic        vga_we;
    logic        busy;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;
    int exp_own;

    vga_draw_arbiter #(.NUM_REQ(4), .IDX_W(2), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .resetn(resetn), .req(req), .eng_done(eng_done), .eng_we(eng_we),
        .eng_x(eng_x), .eng_y(eng_y), .eng_color(eng_color), .eng_go(eng_go),
        .eng_resetn(eng_resetn), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
        .vga_we(vga_we), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        req       = 4'b0000;
        eng_done  = 4'b0000;
        eng_we    = 4'b0000;
        eng_x     = {8'd40, 8'd30, 8'd20, 8'd10};
        eng_y     = {7'd4, 7'd3, 7'd2, 7'd1};
        eng_color = {3'd4, 3'd3, 3'd2, 3'd1};
        tick();
        tick();
        check("rst_go", 32'(eng_go), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h3);
        check("rst_engrst", 32'(eng_resetn), 32'h0);
        check("rst_we", 32'(vga_we), 32'h0);
        check("rst_x", 32'(vga_x), 32'h0);

        // Single request, long draw
        resetn = 1'b1;
        tick();
        check("idle_engrst", 32'(eng_resetn), 32'hF);
        req    = 4'b0001;
        eng_we = 4'b0001;
        tick();
        check("t1_go", 32'(eng_go), 32'h1);
        check("t1_owner", 32'(owner), 32'h0);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_x", 32'(vga_x), 32'd10);
        check("t1_y", 32'(vga_y), 32'd1);
        check("t1_col", 32'(vga_color), 32'd1);
        check("t1_we", 32'(vga_we), 32'h1);
        repeat (60) tick();
        check("t1_go_held", 32'(eng_go), 32'h1);
        eng_done = 4'b0001;
        tick();
        check("t1_rel_go", 32'(eng_go), 32'h0);
        check("t1_rel_engrst", 32'(eng_resetn), 32'hE);
        check("t1_rel_busy", 32'(busy), 32'h1);
        check("t1_rel_we", 32'(vga_we), 32'h0);
        eng_done = 4'b0000;
        req      = 4'b0000;
        tick();
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_idle_engrst", 32'(eng_resetn), 32'hF);
        check("t1_idle_owner", 32'(owner), 32'h0);

        // All requesting: fresh reset so engine 0 leads
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req    = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_own = g % 4;
            tick();
            check("rr_owner", 32'(owner), 32'(exp_own));
            check("rr_go", 32'(eng_go), 32'(1 << exp_own));
            tick();
            tick();
            check("rr_go_held", 32'(eng_go), 32'(1 << exp_own));
            eng_done = 4'(1 << exp_own);
            tick();
            check("rr_rel_go", 32'(eng_go), 32'h0);
            check("rr_rel_engrst", 32'(eng_resetn), 32'(~(1 << exp_own) & 4'hF));
            eng_done = 4'b0000;
            if (g == 4) req = 4'b0000;
            tick();
            check("rr_idle_go", 32'(eng_go), 32'h0);
            check("rr_idle_busy", 32'(busy), 32'h0);
        end

        // Owner 2 then req 0101: 0 first, then 2
        req = 4'b0100;
        tick();
        check("t3_own2", 32'(owner), 32'h2);
        eng_done = 4'b0100;
        tick();
        eng_done = 4'b0000;
        req      = 4'b0101;
        tick();
        tick();
        check("t3_own0", 32'(owner), 32'h0);
        check("t3_go0", 32'(eng_go), 32'h1);
        eng_done = 4'b0001;
        tick();
        eng_done = 4'b0000;
        req      = 4'b0100;
        tick();
        tick();
        check("t3_own2b", 32'(owner), 32'h2);

        // Non-owner pixel traffic is ignored
        eng_we = 4'b0101;
        #1;
        check("t5_x", 32'(vga_x), 32'd30);
        check("t5_y", 32'(vga_y), 32'd3);
        check("t5_we", 32'(vga_we), 32'h1);
        eng_we = 4'b0001;
        #1;
        check("t5_we_nonowner", 32'(vga_we), 32'h0);
        req = 4'b0000;
        tick();
        check("t5_rel_engrst", 32'(eng_resetn), 32'hB);
        check("t5_rel_x", 32'(vga_x), 32'h0);
        eng_we = 4'b1111;
        tick();
        check("t5_idle_we", 32'(vga_we), 32'h0);
        check("t5_idle_x", 32'(vga_x), 32'h0);
        check("t5_idle_y", 32'(vga_y), 32'h0);
        check("t5_idle_col", 32'(vga_color), 32'h0);

        // Abort of engine 1 mid-draw
        req = 4'b0010;
        tick();
        check("t4_own1", 32'(owner), 32'h1);
        check("t4_we", 32'(vga_we), 32'h1);
        tick();
        req = 4'b0000;
        tick();
        check("t4_rel_engrst", 32'(eng_resetn), 32'hD);
        check("t4_rel_we", 32'(vga_we), 32'h0);
        tick();
        check("t4_idle_we", 32'(vga_we), 32'h0);
        check("t4_idle_busy", 32'(busy), 32'h0);

        // Off-screen coordinates
        eng_we = 4'b0001;
        eng_x  = {8'd40, 8'd30, 8'd20, 8'd170};
        eng_y  = {7'd4, 7'd3, 7'd2, 7'd10};
        req    = 4'b0001;
        tick();
        check("clip_own0", 32'(owner), 32'h0);
        check("clip_x", 32'(vga_x), 32'd170);
`ifdef ARB_CLIP_EN
        check("clip_we_off", 32'(vga_we), 32'h0);
        eng_x = {8'd40, 8'd30, 8'd20, 8'd159};
        eng_y = {7'd4, 7'd3, 7'd2, 7'd119};
        #1;
        check("clip_we_edge", 32'(vga_we), 32'h1);
`else
        check("noclip_we", 32'(vga_we), 32'h1);
`endif

        // Synchronous reset while busy
        resetn = 1'b0;
        #1;
        check("mid_rst_engrst", 32'(eng_resetn), 32'h0);
        tick();
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_go", 32'(eng_go), 32'h0);
        check("mid_rst_owner", 32'(owner), 32'h3);
        resetn = 1'b1;
        req    = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
